// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store requester: access sizes, FSM states,
// byte-lane mask generation and load-data extraction/extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StResp
    } lsu_state_e;

    // Byte lanes touched across two consecutive words; size 2'b11 behaves as a word.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic is_unsigned);
        logic [63:0] s;
        logic [31:0] r;
        s = raw >> {off, 3'b000};
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            SZ_HALF: r = is_unsigned ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s[31:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational merge/shift/extend of a two-word load window {hi,lo} into one
// right-justified, sign- or zero-extended 32-bit value.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);

    assign data_o = load_extend(raw_i, off_i, size_i, is_unsigned_i);

endmodule

// File: rtl/lsu_mem_requester.sv
// Single-outstanding load/store requester with word-boundary splitting.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of splitting.
module lsu_mem_requester
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    lsu_state_e  state_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [3:0]  hi_be_q;
    logic [31:0] hi_wd_q;
    logic [31:0] lo_q;

    logic [7:0]  acc_mask;
    logic [63:0] acc_wd;
    logic [63:0] align_raw;
    logic [31:0] align_data;

    always_comb begin
        acc_mask = byte_mask(req_size, req_addr[1:0]);
        acc_wd   = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    // Second word arrives live on mem_rd during ACC1, so only lo needs holding.
    always_comb begin
        align_raw = {32'h0, mem_rd};
        if (state_q == StAcc1) begin
            align_raw = {mem_rd, lo_q};
        end
    end

    lsu_load_align u_load_align (
        .raw_i        (align_raw),
        .off_i        (off_q),
        .size_i       (size_q),
        .is_unsigned_i(uns_q),
        .data_o       (align_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic trap_q;
    logic err_q;

    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            hi_be_q    <= 4'h0;
            hi_wd_q    <= 32'h0;
            lo_q       <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= '0;
            mem_wd     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        off_q     <= req_addr[1:0];
                        hi_be_q   <= acc_mask[7:4];
                        hi_wd_q   <= acc_wd[63:32];
                        req_ready <= 1'b0;
                        mem_be    <= acc_mask[3:0];
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wd    <= acc_wd[31:0];
`ifdef LSU_MISALIGN_TRAP_EN
                        trap_q    <= misalign;
                        mem_en    <= !misalign;
                        mem_we    <= req_store && !misalign;
`else
                        mem_en    <= 1'b1;
                        mem_we    <= req_store;
`endif
                        state_q   <= StAcc0;
                    end
                end
                StAcc0: begin
                    lo_q <= mem_rd;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (trap_q) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        err_q      <= 1'b1;
                        mem_be     <= 4'h0;
                        mem_addr   <= '0;
                        mem_wd     <= '0;
                    end else
`endif
                    if (hi_be_q != 4'h0) begin
                        state_q  <= StAcc1;
                        mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        mem_be   <= hi_be_q;
                        mem_wd   <= hi_wd_q;
                    end else begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= store_q ? '0 : align_data;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'h0;
                        mem_addr   <= '0;
                        mem_wd     <= '0;
                    end
                end
                StAcc1: begin
                    state_q    <= StResp;
                    resp_valid <= 1'b1;
                    resp_rdata <= store_q ? '0 : align_data;
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_be     <= 4'h0;
                    mem_addr   <= '0;
                    mem_wd     <= '0;
                end
                StResp: begin
                    state_q    <= StIdle;
                    req_ready  <= 1'b1;
                    resp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_q      <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_requester.md
Name: lsu_mem_requester

Overview:
CPU-side load/store requester that drives the data-memory port from the pipeline's memory stage.
- Accepts one load or store at a time: byte, half or word, signed or unsigned.
- Generates word-aligned memory accesses with byte enables.
- Splits accesses that cross a word boundary into two memory accesses.
- Merges and extends load data, then returns a single response.

Parameters:
ADDR_WIDTH, 32, byte address width (memory address always word-aligned, bits [1:0]=0)
DATA_WIDTH, 32, data width; only 32 supported

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
req_store  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  load zero-extend (1) / sign-extend (0)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-justified
resp_valid  output  1  one-cycle completion pulse (loads and stores)
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores
resp_err  output  1  misalignment error flag (feature only, else constant 0)
mem_en  output  1  memory access this cycle
mem_we  output  1  write strobe; only asserted together with mem_en
mem_be  output  4  byte enables
mem_addr  output  ADDR_WIDTH  word-aligned address
mem_wd  output  DATA_WIDTH  lane-aligned write data
mem_rd  input  DATA_WIDTH  combinational read data for mem_addr in the same cycle

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM state IDLE.
- FSM states: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
- Accept cycle T: latch store, size, unsigned, addr, wdata. Compute:
  - n bytes = 1, 2 or 4.
  - off = addr[1:0].
  - 8-bit mask = ((1<<n)-1)<<off.
  - 64-bit shifted wdata = wdata<<(8*off).
  - cross = mask[7:4]!=0.
- ACC0 (T+1):
  - mem_en=1; mem_addr={addr[ADDR_WIDTH-1:2],2'b00}; mem_be=mask[3:0]; mem_wd=shifted[31:0]; mem_we=store.
  - Loads capture mem_rd as lo.
  - Next state is ACC1 if cross, else RESP.
- ACC1 (T+2, split only):
  - mem_addr=word0+4, wrapping modulo 2^ADDR_WIDTH; mem_be=mask[7:4]; mem_wd=shifted[63:32].
  - Loads capture mem_rd as hi.
- RESP:
  - resp_valid=1 for exactly one cycle; mem_en=0.
  - resp_rdata = ({hi,lo}>>(8*off)) truncated to n bytes, then sign/zero-extended. hi=0 when not split.
- Latency: non-split resp_valid at T+2; split at T+3. Throughput is one request per 3 or 4 cycles; no request is accepted in RESP.
- Half at off=1 does not split (mask 0110); half at off=3 splits; word at off≠0 splits.
- Reset mid-operation: immediate return to IDLE. mem_en/mem_we drop asynchronously. No resp_valid. A half-completed split store leaves word0 written; this is permitted.
- req_* inputs are ignored outside the accept cycle.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: any request with (half && off[0]) or (word && off≠0) skips ACC0/ACC1, issues no mem_en, and goes straight to RESP with resp_err=1 and resp_rdata=0 (latency T+1→resp at T+2).
- Undefined: splitting as above; resp_err tied 0.

Decomposition:
- Package lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum.
  - function byte_mask(size, off) returning 8 bits.
  - function load_extend(raw64, off, size, unsigned) returning 32 bits.
- One sub-module, lsu_load_align: combinational merge/shift/extend of {hi,lo}; reusable by a future cache.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> ACC0 be=1111 addr 0x100 wd 0xDEADBEEF; load resp_rdata=0xDEADBEEF at T+2.
- Signed byte load @0x103 with mem[0x100]=0xDEADBEEF -> be=1000, resp_rdata=0xFFFFFFDE; unsigned -> 0x000000DE.
- Word store 0x11223344 @0x102 -> ACC0 addr 0x100 be=1100 wd 0x33440000; ACC1 addr 0x104 be=0011 wd 0x00001122; resp_valid at T+3.
- Signed half load @0x103 with mem[0x100]=0x80xxxxxx, mem[0x104]=0xxxxxxxFF -> resp_rdata=0xFFFFFF80. Under LSU_MISALIGN_TRAP_EN: no mem_en, resp_err=1, resp_rdata=0 at T+2.
- Word load @0xFFFFFFFE -> ACC1 mem_addr 0x00000000 (wrap), be=0011.
- Assert rst during ACC1 of a split store -> mem_we low immediately, no resp_valid, req_ready=1 after release; the next request completes normally.
